// File: rtl/if_id_stage.sv
// if_id_stage: instruction fetch with PC register, IF/ID pipeline register and saturating stall counter.
module if_id_stage #(
    parameter int                      PC_WIDTH        = 32,
    parameter int                      INSTR_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC        = '0,
    parameter logic [INSTR_WIDTH-1:0]  NOP_WORD        = '0,
    parameter int                      STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       R,
    input  logic                       in_LE,
    input  logic                       in_branch_taken,
    input  logic [PC_WIDTH-1:0]        in_branch_target,
    input  logic [INSTR_WIDTH-1:0]     in_instr,
    output logic [PC_WIDTH-1:0]        out_imem_addr,
    output logic [INSTR_WIDTH-1:0]     ID_instr,
    output logic [PC_WIDTH-1:0]        ID_next_pc,
    output logic                       ID_valid,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus4;

    assign pc_plus4      = pc + PC_WIDTH'(4);
    assign out_imem_addr = pc;

    // A taken branch outranks a stall and squashes the instruction fetched this cycle.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            pc          <= RESET_PC;
            ID_instr    <= NOP_WORD;
            ID_next_pc  <= '0;
            ID_valid    <= 1'b0;
            stall_count <= '0;
        end else if (in_branch_taken) begin
            pc         <= in_branch_target;
            ID_instr   <= NOP_WORD;
            ID_next_pc <= pc_plus4;
            ID_valid   <= 1'b0;
        end else if (!in_LE) begin
            stall_count <= (&stall_count) ? stall_count : stall_count + 1'b1;
        end else begin
            pc         <= pc_plus4;
            ID_instr   <= in_instr;
            ID_next_pc <= pc_plus4;
            ID_valid   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed checks of fetch, stall, branch, wrap, saturation and async reset.
module tb_if_id_stage;
    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic        in_LE = 1'b1;
    logic        in_branch_taken = 1'b0;
    logic [31:0] in_branch_target = '0;
    logic [31:0] in_instr;
    logic [31:0] out_imem_addr;
    logic [31:0] ID_instr;
    logic [31:0] ID_next_pc;
    logic        ID_valid;
    logic [15:0] stall_count;

    logic        r2 = 1'b1;
    logic        le2 = 1'b1;
    logic [31:0] addr2, instr2, next2;
    logic        valid2;
    logic [1:0]  cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word at address A reads as 0xE0000000 + A.
    assign in_instr = 32'hE000_0000 + out_imem_addr;

    if_id_stage dut (
        .clk(clk), .R(R), .in_LE(in_LE), .in_branch_taken(in_branch_taken),
        .in_branch_target(in_branch_target), .in_instr(in_instr),
        .out_imem_addr(out_imem_addr), .ID_instr(ID_instr), .ID_next_pc(ID_next_pc),
        .ID_valid(ID_valid), .stall_count(stall_count)
    );

    if_id_stage #(.STALL_CNT_WIDTH(2)) dut2 (
        .clk(clk), .R(r2), .in_LE(le2), .in_branch_taken(1'b0),
        .in_branch_target(32'h0), .in_instr(32'h0),
        .out_imem_addr(addr2), .ID_instr(instr2), .ID_next_pc(next2),
        .ID_valid(valid2), .stall_count(cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        #2 R = 1'b0; r2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_LE = i[0];
            in_branch_taken = ~i[0];
            in_branch_target = 32'h300 + 32'(i);
            step();
        end
        chk("rst_addr", out_imem_addr, 0);
        chk("rst_valid", ID_valid, 0);
        chk("rst_instr", ID_instr, 0);
        chk("rst_nextpc", ID_next_pc, 0);
        chk("rst_stall", stall_count, 0);

        R = 1'b1; in_LE = 1'b1; in_branch_taken = 1'b0;
        step();
        chk("first_instr", ID_instr, 32'hE000_0000);
        chk("first_nextpc", ID_next_pc, 4);
        chk("first_valid", ID_valid, 1);
        chk("first_addr", out_imem_addr, 4);
        step();
        chk("second_instr", ID_instr, 32'hE000_0004);
        step(); step();
        chk("seq_addr10", out_imem_addr, 32'h10);
        chk("seq_instr", ID_instr, 32'hE000_000C);

        in_LE = 1'b0;
        step(); step(); step();
        chk("stall_addr", out_imem_addr, 32'h10);
        chk("stall_instr", ID_instr, 32'hE000_000C);
        chk("stall_nextpc", ID_next_pc, 32'h10);
        chk("stall_cnt3", stall_count, 3);
        in_LE = 1'b1;
        step();
        chk("unstall_instr", ID_instr, 32'hE000_0010);
        chk("unstall_addr", out_imem_addr, 32'h14);
        step(); step(); step();
        chk("pre_br_addr", out_imem_addr, 32'h20);

        in_branch_taken = 1'b1; in_branch_target = 32'h100;
        step();
        chk("br_addr", out_imem_addr, 32'h100);
        chk("br_valid", ID_valid, 0);
        chk("br_instr", ID_instr, 0);
        in_branch_taken = 1'b0;
        step();
        chk("br_tgt_instr", ID_instr, 32'hE000_0100);
        chk("br_tgt_nextpc", ID_next_pc, 32'h104);
        chk("br_tgt_valid", ID_valid, 1);

        in_LE = 1'b0; in_branch_taken = 1'b1; in_branch_target = 32'h40;
        step();
        chk("brstall_addr", out_imem_addr, 32'h40);
        chk("brstall_valid", ID_valid, 0);
        chk("brstall_cnt", stall_count, 3);
        in_LE = 1'b1; in_branch_taken = 1'b0;
        step();
        chk("brstall_instr", ID_instr, 32'hE000_0040);

        in_branch_taken = 1'b1; in_branch_target = 32'hFFFF_FFFC;
        step();
        chk("wrap_pre", out_imem_addr, 32'hFFFF_FFFC);
        in_branch_taken = 1'b0;
        step();
        chk("wrap_addr", out_imem_addr, 0);
        chk("wrap_nextpc", ID_next_pc, 0);
        chk("wrap_instr", ID_instr, 32'hDFFF_FFFC);

        r2 = 1'b1; le2 = 1'b0;
        step(); step();
        chk("sat_cnt2", cnt2, 2);
        step(); step(); step();
        chk("sat_hold", cnt2, 3);
        chk("sat_addr", addr2, 0);

        in_branch_taken = 1'b1; in_branch_target = 32'h50;
        step();
        in_branch_target = 32'h58;
        step();
        chk("b2b_valid", ID_valid, 0);
        chk("b2b_addr", out_imem_addr, 32'h58);
        in_branch_taken = 1'b0;

        #2 R = 1'b0;
        #1;
        chk("arst_addr", out_imem_addr, 0);
        chk("arst_valid", ID_valid, 0);
        chk("arst_instr", ID_instr, 0);
        chk("arst_nextpc", ID_next_pc, 0);
        chk("arst_stall", stall_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register: holds the PC, drives the instruction memory address, computes PC+4, and latches the fetched instruction for the decode stage.
- Its outputs feed the decode/control unit, whose control bundle is then registered into the ID/EX stage.
- Honours hazard-unit stalls (load enable) and taken-branch flushes.
- Keeps a saturating stall-cycle counter for debug.

Parameters:
- PC_WIDTH, 32, width of the PC, memory address and next-PC paths.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_WORD, 32'h00000000, instruction word inserted into ID on a bubble.
- STALL_CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- R  input  1  reset, asynchronous, active-low (0 = reset).
- in_LE  input  1  load enable from the hazard unit; 0 = stall PC and IF/ID.
- in_branch_taken  input  1  taken branch resolved in ID; redirect and flush.
- in_branch_target  input  PC_WIDTH  branch target address.
- in_instr  input  INSTR_WIDTH  instruction memory read data for out_imem_addr (combinational, same cycle).
- out_imem_addr  output  PC_WIDTH  current PC, driven straight from the PC register.
- ID_instr  output  INSTR_WIDTH  registered instruction for decode.
- ID_next_pc  output  PC_WIDTH  registered PC+4 of the instruction in ID.
- ID_valid  output  1  1 when ID_instr is a real fetched instruction; 0 for a bubble.
- stall_count  output  STALL_CNT_WIDTH  saturating count of stall cycles since reset.

Behaviour:
- Reset (R=0, asynchronous, effective immediately without a clock edge):
  - PC = RESET_PC.
  - ID_instr = NOP_WORD, ID_next_pc = 0, ID_valid = 0, stall_count = 0.
- Reset release: the first rising edge with R=1 performs a normal update. The fetch of RESET_PC happens in the cycle after release.
- pc_plus4 = PC + 4, truncated to PC_WIDTH. It wraps, e.g. 0xFFFFFFFC -> 0x00000000.
- Per rising edge with R=1, priority is highest first:
  - in_branch_taken=1 (regardless of in_LE):
    - PC <= in_branch_target.
    - ID_instr <= NOP_WORD, ID_valid <= 0, ID_next_pc <= pc_plus4 (don't-care for verification).
    - The instruction fetched this cycle is discarded.
  - in_LE=0:
    - PC, ID_instr, ID_next_pc and ID_valid hold their values.
    - stall_count <= stall_count + 1, unless it is all-ones, in which case it holds (saturates).
  - Otherwise (normal advance):
    - PC <= pc_plus4.
    - ID_instr <= in_instr, ID_next_pc <= pc_plus4, ID_valid <= 1.
- stall_count increments only in the in_LE=0 branch. A cycle with branch taken and in_LE=0 does not count as a stall.
- Latency: the instruction at address A appears on ID_instr one edge after out_imem_addr = A, given in_LE=1 and no branch.
- Branch target fetch: the target is fetched in the cycle after the branch edge and reaches ID one edge later. That gives exactly one bubble per taken branch.
- Back-to-back branches: each edge with in_branch_taken=1 redirects again. ID_valid stays 0 throughout.
- The target address is used as given. Low two bits are not forced to 0; alignment is the producer's responsibility.
- Reset mid-stall or mid-branch: asynchronous clear wins. No pending redirect survives reset.
- Outputs are registered only. out_imem_addr is the PC register output, so there is no combinational path from any input to any output.

Test Plan:
1. Reset and release: hold R=0 with toggling inputs -> out_imem_addr=0, ID_valid=0, ID_instr=0, stall_count=0. Release R, in_LE=1, memory returns 0xE0000000+addr -> ID_instr=0xE0000000, ID_next_pc=4, ID_valid=1 after the first edge; sequence continues 0xE0000004/8, ...
2. Stall: at PC=0x10, in_LE=0 for 3 cycles -> out_imem_addr stays 0x10, ID outputs frozen, stall_count=3. Reassert in_LE -> ID_instr=mem[0x10], PC=0x14.
3. Branch: at PC=0x20, in_branch_taken=1, target=0x100 -> next cycle out_imem_addr=0x100, ID_valid=0, ID_instr=NOP. Following edge -> ID_instr=mem[0x100], ID_next_pc=0x104, ID_valid=1.
4. Branch during stall: in_LE=0 and in_branch_taken=1, target=0x40 -> PC=0x40, bubble in ID, stall_count unchanged.
5. Wrap and saturation: PC=0xFFFFFFFC advance -> PC=0, ID_next_pc=0. Force stall_count to 0xFFFE, stall 3 cycles -> stall_count holds 0xFFFF.
6. Asynchronous reset mid-operation: assert R=0 between clock edges while PC=0x58 -> outputs cleared before the next edge, PC=RESET_PC.
